// File: rtl/data_sram_resp.sv
// data_sram_resp: single-port word SRAM on a byte-addressed data bus.
// Read-first with a registered read port. Illegal accesses return zero and
// leave a sticky error with the address of the first one. Saturating
// read and write activity counters.
module data_sram_resp #(
  parameter int          DEPTH_LOG2 = 10,
  parameter logic [31:0] BASE_ADDR  = 32'h1c00_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_we,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        rd_valid,
  output logic        err_sticky,
  output logic [31:0] err_addr,
  output logic [15:0] wr_cnt,
  output logic [15:0] rd_cnt
);

  localparam int WORDS = 1 << DEPTH_LOG2;

  // Storage array. It has no reset, so its contents survive a reset.
  logic [31:0] mem [WORDS];

  logic [DEPTH_LOG2-1:0] word_idx;
  logic                  in_range;
  logic                  we_legal;
  logic                  accept;
  logic                  acc_ok;
  logic                  acc_bad;
  logic                  do_write;
  logic                  do_read;
  logic [3:0]            lane_we;
  logic                  unused_low_addr;

  logic [31:0] rdata_q, rdata_d;
  logic        rd_valid_q, rd_valid_d;
  logic        err_sticky_q, err_sticky_d;
  logic [31:0] err_addr_q, err_addr_d;
  logic [15:0] wr_cnt_q, wr_cnt_d;
  logic [15:0] rd_cnt_q, rd_cnt_d;

  // The byte offset does not take part in word selection.
  assign unused_low_addr = ^data_sram_addr[1:0];

  assign word_idx = data_sram_addr[DEPTH_LOG2+1:2];
  assign in_range = (data_sram_addr[31:DEPTH_LOG2+2] == BASE_ADDR[31:DEPTH_LOG2+2]);

  // Accepted write-enable shapes are single bytes, aligned halves and the full word.
  always_comb begin
    we_legal = 1'b0;
    case (data_sram_we)
      4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000,
      4'b0011, 4'b1100, 4'b1111: we_legal = 1'b1;
      default:                   we_legal = 1'b0;
    endcase
  end

  // A reset in the same cycle as an access cancels that access.
  assign accept   = data_sram_en & ~reset;
  assign acc_ok   = accept & in_range & we_legal;
  assign acc_bad  = accept & ~(in_range & we_legal);
  assign do_write = acc_ok & (|data_sram_we);
  assign do_read  = acc_ok & ~(|data_sram_we);

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign lane_we[gi] = do_write & data_sram_we[gi];
    end
  endgenerate

  // Array write: only the enabled byte lanes change.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (lane_we[i]) begin
        mem[word_idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
      end
    end
  end

  // Next-state values for the registered outputs.
  always_comb begin
    rdata_d      = rdata_q;
    rd_valid_d   = 1'b0;
    err_sticky_d = err_sticky_q;
    err_addr_d   = err_addr_q;
    wr_cnt_d     = wr_cnt_q;
    rd_cnt_d     = rd_cnt_q;

    if (acc_ok) begin
      // Read-first: the pre-write word is returned even on a write.
      rdata_d    = mem[word_idx];
      rd_valid_d = do_read;
    end else if (acc_bad) begin
      rdata_d = 32'h0;
      if (!err_sticky_q) begin
        err_sticky_d = 1'b1;
        err_addr_d   = data_sram_addr;
      end
    end

    if (do_write && (wr_cnt_q != 16'hFFFF)) begin
      wr_cnt_d = wr_cnt_q + 16'd1;
    end
    if (do_read && (rd_cnt_q != 16'hFFFF)) begin
      rd_cnt_d = rd_cnt_q + 16'd1;
    end
  end

  // Output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q      <= 32'h0;
      rd_valid_q   <= 1'b0;
      err_sticky_q <= 1'b0;
      err_addr_q   <= 32'h0;
      wr_cnt_q     <= 16'h0;
      rd_cnt_q     <= 16'h0;
    end else begin
      rdata_q      <= rdata_d;
      rd_valid_q   <= rd_valid_d;
      err_sticky_q <= err_sticky_d;
      err_addr_q   <= err_addr_d;
      wr_cnt_q     <= wr_cnt_d;
      rd_cnt_q     <= rd_cnt_d;
    end
  end

  assign data_sram_rdata = rdata_q;
  assign rd_valid        = rd_valid_q;
  assign err_sticky      = err_sticky_q;
  assign err_addr        = err_addr_q;
  assign wr_cnt          = wr_cnt_q;
  assign rd_cnt          = rd_cnt_q;

endmodule

// File: tb/tb_data_sram_resp.sv
// Testbench for data_sram_resp: directed vectors, a behavioural model
// checked every cycle, plus literal expectations at the key points.
module tb_data_sram_resp;

  localparam int          DL2   = 10;
  localparam logic [31:0] BASE  = 32'h1c00_0000;
  localparam int          WORDS = 1 << DL2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b0;
  logic [3:0]  we = 4'b0000;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic [31:0] rdata;
  logic        rd_valid;
  logic        err_sticky;
  logic [31:0] err_addr;
  logic [15:0] wr_cnt;
  logic [15:0] rd_cnt;

  int n_vec = 0;
  int n_bad = 0;

  data_sram_resp #(.DEPTH_LOG2(DL2), .BASE_ADDR(BASE)) dut (
    .clk             (clk),
    .reset           (reset),
    .data_sram_en    (en),
    .data_sram_we    (we),
    .data_sram_addr  (addr),
    .data_sram_wdata (wdata),
    .data_sram_rdata (rdata),
    .rd_valid        (rd_valid),
    .err_sticky      (err_sticky),
    .err_addr        (err_addr),
    .wr_cnt          (wr_cnt),
    .rd_cnt          (rd_cnt)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [31:0] m_mem   [int];
  logic [3:0]  m_known [int];
  logic [31:0] x_rdata = 32'h0;
  bit          x_rdata_known = 1'b1;
  bit          x_valid = 1'b0;
  bit          x_err = 1'b0;
  logic [31:0] x_err_addr = 32'h0;
  int          x_wr = 0;
  int          x_rd = 0;
  bit          model_live = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      x_rdata = 0; x_rdata_known = 1; x_valid = 0;
      x_err = 0; x_err_addr = 0; x_wr = 0; x_rd = 0;
      model_live = 1;
    end else begin
      x_valid = 0;
      if (en) begin
        int w;
        bit ok;
        w  = int'((addr >> 2) % WORDS);
        ok = ((addr >> (DL2 + 2)) == (BASE >> (DL2 + 2))) &&
             (we inside {4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000,
                         4'b0011, 4'b1100, 4'b1111});
        if (ok) begin
          if (!m_mem.exists(w)) begin m_mem[w] = 0; m_known[w] = 0; end
          x_rdata       = m_mem[w];
          x_rdata_known = (m_known[w] == 4'hF);
          if (we == 0) begin
            x_valid = 1;
            if (x_rd < 65535) x_rd++;
          end else begin
            for (int b = 0; b < 4; b++)
              if (we[b]) begin
                m_mem[w][8*b +: 8] = wdata[8*b +: 8];
                m_known[w][b] = 1'b1;
              end
            if (x_wr < 65535) x_wr++;
          end
        end else begin
          x_rdata = 0; x_rdata_known = 1;
          if (!x_err) begin x_err = 1; x_err_addr = addr; end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: every cycle once the model has seen reset.
  always @(negedge clk) begin
    if (model_live) begin
      if (x_rdata_known) chk("m_rdata", rdata, x_rdata);
      chk("m_rd_valid",   {31'b0, rd_valid},   {31'b0, x_valid});
      chk("m_err_sticky", {31'b0, err_sticky}, {31'b0, x_err});
      chk("m_err_addr",   err_addr, x_err_addr);
      chk("m_wr_cnt",     {16'b0, wr_cnt}, 32'(x_wr));
      chk("m_rd_cnt",     {16'b0, rd_cnt}, 32'(x_rd));
    end
  end

  // Drive one cycle from a negedge; returns at the next negedge.
  task automatic acc(input logic e, input logic [3:0] w, input logic [31:0] a,
                     input logic [31:0] d);
    en = e; we = w; addr = a; wdata = d;
    @(negedge clk);
    $display("acc en=%0d we=%b addr=%h wdata=%h -> rdata=%h vld=%0d err=%0d wr=%0d rd=%0d",
             e, w, a, d, rdata, rd_valid, err_sticky, wr_cnt, rd_cnt);
  endtask

  initial begin
    reset = 1;
    repeat (3) @(negedge clk);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_wr_cnt", {16'b0, wr_cnt}, 32'h0);
    reset = 0;

    // Full-word round trip
    acc(1, 4'b1111, 32'h1c00_0010, 32'hDEADBEEF);
    acc(1, 4'b0000, 32'h1c00_0010, 32'h0);
    chk("rt_rdata", rdata, 32'hDEADBEEF);
    chk("rt_valid", {31'b0, rd_valid}, 32'h1);
    chk("rt_wr_cnt", {16'b0, wr_cnt}, 32'd1);
    chk("rt_rd_cnt", {16'b0, rd_cnt}, 32'd1);

    // Byte and half-word merging
    acc(1, 4'b0010, 32'h1c00_0010, 32'h55555555);
    acc(1, 4'b1100, 32'h1c00_0010, 32'hAAAAAAAA);
    acc(1, 4'b0000, 32'h1c00_0011, 32'h0);
    chk("merge_rdata", rdata, 32'hAAAA55EF);

    // Read-first collision
    acc(1, 4'b1111, 32'h1c00_0020, 32'h11111111);
    acc(1, 4'b1111, 32'h1c00_0020, 32'h22222222);
    chk("rf_old", rdata, 32'h11111111);
    chk("rf_valid", {31'b0, rd_valid}, 32'h0);
    acc(1, 4'b0000, 32'h1c00_0020, 32'h0);
    chk("rf_new", rdata, 32'h22222222);

    // Errors: illegal we, then out-of-range read
    acc(1, 4'b0101, 32'h1c00_0030, 32'h99999999);
    chk("e1_rdata", rdata, 32'h0);
    chk("e1_err", {31'b0, err_sticky}, 32'h1);
    chk("e1_addr", err_addr, 32'h1c00_0030);
    acc(1, 4'b0000, 32'h2000_0000, 32'h0);
    chk("e2_rdata", rdata, 32'h0);
    chk("e2_addr", err_addr, 32'h1c00_0030);
    chk("e2_wr_cnt", {16'b0, wr_cnt}, 32'd5);
    chk("e2_rd_cnt", {16'b0, rd_cnt}, 32'd3);
    acc(1, 4'b0000, 32'h1c00_0030, 32'h0);
    acc(1, 4'b0000, 32'h1c00_0020, 32'h0);
    chk("e_arr_unch", rdata, 32'h22222222);

    // en=0 hold
    for (int i = 0; i < 3; i++) begin
      acc(0, 4'b1111, 32'h1c00_0020, 32'h77777777);
      chk("hold_rdata", rdata, 32'h22222222);
      chk("hold_valid", {31'b0, rd_valid}, 32'h0);
    end

    // Counter saturation
    en = 1; we = 4'b0000; addr = 32'h1c00_0010; wdata = 0;
    repeat (65540) @(negedge clk);
    chk("sat_rd_cnt", {16'b0, rd_cnt}, 32'h0000FFFF);

    // Reset mid-stream
    acc(1, 4'b1111, 32'h1c00_0040, 32'hCAFEF00D);
    reset = 1;
    acc(1, 4'b1111, 32'h1c00_0040, 32'hBADBAD00);
    chk("mr_rdata", rdata, 32'h0);
    chk("mr_err", {31'b0, err_sticky}, 32'h0);
    chk("mr_err_addr", err_addr, 32'h0);
    chk("mr_rd_cnt", {16'b0, rd_cnt}, 32'h0);
    reset = 0;
    acc(1, 4'b0000, 32'h1c00_0040, 32'h0);
    chk("mr_keep40", rdata, 32'hCAFEF00D);
    acc(1, 4'b0000, 32'h1c00_0010, 32'h0);
    chk("mr_keep10", rdata, 32'hAAAA55EF);
    chk("mr_wr_cnt", {16'b0, wr_cnt}, 32'd0);
    chk("mr_rd_cnt2", {16'b0, rd_cnt}, 32'd2);
    acc(0, 4'b0000, 32'h0, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/data_sram_resp.md
DATA_SRAM_RESP -- requirements
Module: data_sram_resp

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 10, meaning log2 of the number of 32-bit words.
REQ-002 SHALL have parameter BASE_ADDR, default 32'h1c00_0000, meaning the byte address of word 0 (aligned to 4*2^DEPTH_LOG2).
REQ-003 SHALL have port clk, input, 1 bit: the clock, rising edge.
REQ-004 SHALL have port reset, input, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL have port data_sram_en, input, 1 bit: access enable.
REQ-006 SHALL have port data_sram_we, input, 4 bits: byte-lane write enables, bit i = byte lane i; 0 means read.
REQ-007 SHALL have port data_sram_addr, input, 32 bits: byte address.
REQ-008 SHALL have port data_sram_wdata, input, 32 bits: write data, lane-replicated by the initiator.
REQ-009 SHALL have port data_sram_rdata, output, 32 bits: registered read data.
REQ-010 SHALL have port rd_valid, output, 1 bit: data_sram_rdata belongs to a legal read accepted in the previous cycle.
REQ-011 SHALL have port err_sticky, output, 1 bit: at least one illegal access since reset.
REQ-012 SHALL have port err_addr, output, 32 bits: byte address of the first illegal access.
REQ-013 SHALL have port wr_cnt, output, 16 bits: count of performed writes, saturating.
REQ-014 SHALL have port rd_cnt, output, 16 bits: count of performed reads, saturating.

Function
REQ-015 SHALL hold 2^DEPTH_LOG2 words; word index = addr[DEPTH_LOG2+1:2].
REQ-016 SHALL treat an address as in range iff addr[31:DEPTH_LOG2+2] == BASE_ADDR[31:DEPTH_LOG2+2]; addr[1:0] is ignored for indexing.
REQ-017 SHALL accept an access on every rising edge where en=1; no back-pressure; one access per cycle.
REQ-018 SHALL treat legal we values as 0000, 0001, 0010, 0100, 1000, 0011, 1100, 1111; all others are illegal.
REQ-019 SHALL, on an in-range write with legal we, update only the enabled byte lanes of the indexed word from the same wdata lanes, and increment wr_cnt.
REQ-020 SHALL make a write visible to any access from the next cycle onward.
REQ-021 SHALL, on every accepted access (read or write), load data_sram_rdata with the indexed word's pre-write contents (read-first), giving a read latency of 1 cycle.
REQ-022 SHALL assert rd_valid for exactly one cycle after an in-range access with we=0000, and increment rd_cnt at that access.
REQ-023 SHALL, on an out-of-range access or an illegal we: perform no array update, load data_sram_rdata with 0, keep rd_valid low, and increment neither counter.
REQ-024 SHALL, on the first illegal access, set err_sticky and capture err_addr; later errors leave err_addr unchanged.
REQ-025 SHALL, when en=0, hold data_sram_rdata, drive rd_valid=0, write nothing, and leave the counters unchanged.
REQ-026 SHALL hold wr_cnt and rd_cnt at 16'hFFFF once they saturate.
REQ-027 SHALL keep all outputs registered, with no combinational path from inputs to outputs.

Reset
REQ-028 SHALL, while reset=1: drive data_sram_rdata=0, rd_valid=0, err_sticky=0, err_addr=0, wr_cnt=0, rd_cnt=0, and ignore all accesses.
REQ-029 SHALL not clear the array on reset; contents survive reset, and contents never written are undefined.
REQ-030 SHALL treat reset asserted in the same cycle as an access as the access not occurring.

Verification
REQ-031 SHALL cover a full-word round trip: write we=1111, addr=1c00_0010, wdata=DEADBEEF; next cycle read the same address -> the following cycle rdata=DEADBEEF, rd_valid=1, wr_cnt=1, rd_cnt=1.
REQ-032 SHALL cover byte and half-word merging: word 1c00_0010 holds DEADBEEF; write we=0010 with wdata=55555555, then we=1100 with wdata=AAAA_AAAA; read -> AAAA55EF.
REQ-033 SHALL cover read-first collision: word 1c00_0020 holds 11111111; write 22222222 to it -> rdata 11111111 with rd_valid=0 the next cycle; a following read -> 22222222.
REQ-034 SHALL cover error handling: access with we=0101 at 1c00_0030, then a read at 2000_0000 -> rdata=0 both times, err_sticky=1, err_addr=1c00_0030, counters unchanged, array unchanged.
REQ-035 SHALL cover en=0 hold and counter saturation: en=0 for 3 cycles -> rdata holds, rd_valid=0; after 65540 legal reads, rd_cnt=FFFF.
REQ-036 SHALL cover reset mid-stream: assert reset in the cycle a write to 1c00_0040 is presented -> no write occurs, all outputs go to 0, and previously written words still read back unchanged after reset.
